// File: rtl/load_store_unit.sv
// Load/store unit: sits between the CPU datapath and a word-wide data memory.
// Word loads and word stores take a single memory cycle. Byte and halfword
// stores read the word, patch the addressed lane(s) and write it back.
// Misaligned or illegal-size accesses skip memory and go straight to the
// response state with Fault raised. Bytes are little-endian within a word.
module load_store_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Request,
  input  logic        Write,
  input  logic [1:0]  Size,
  input  logic        SignExtend,
  input  logic [31:0] Address,
  input  logic [31:0] StoreData,
  output logic        Busy,
  output logic        Done,
  output logic        Fault,
  output logic [31:0] LoadData,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemEnableWrite,
  input  logic [31:0] MemReadData
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_t;

  // Everything captured from the CPU when an access is accepted.
  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic        fault_q, fault_d;
  logic [31:0] rdword_q, rdword_d;
  logic [31:0] load_q, load_d;

  logic        req_fault;
  logic        mem_phase;
  logic        wr_phase;

  // Pick the addressed lane out of a memory word and extend it to 32 bits.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        sext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{sext & b[7]}}, b};
      SZ_HALF: r = {{16{sext & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Overlay the low store bits onto the addressed lane(s) of the old word.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic [31:0] data);
    logic [31:0] r;
    r = word;
    if (size == SZ_BYTE) begin
      case (off)
        2'd0:    r[7:0]   = data[7:0];
        2'd1:    r[15:8]  = data[7:0];
        2'd2:    r[23:16] = data[7:0];
        default: r[31:24] = data[7:0];
      endcase
    end else if (size == SZ_HALF) begin
      if (off[1]) r[31:16] = data[15:0];
      else        r[15:0]  = data[15:0];
    end
    return r;
  endfunction

  // Illegal size, or a halfword/word that straddles its natural boundary.
  always_comb begin
    req_fault = 1'b0;
    case (Size)
      SZ_ILL:  req_fault = 1'b1;
      SZ_HALF: req_fault = Address[0];
      SZ_WORD: req_fault = |Address[1:0];
      default: req_fault = 1'b0;
    endcase
  end

  // Next-state logic plus capture of the request, read word and load result.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    fault_d  = fault_q;
    rdword_d = rdword_q;
    load_d   = load_q;
    case (state_q)
      IDLE: begin
        if (Request) begin
          req_d.write = Write;
          req_d.size  = Size;
          req_d.sext  = SignExtend;
          req_d.addr  = Address;
          req_d.wdata = StoreData;
          fault_d     = req_fault;
          if (req_fault)          state_d = RESP;
          else if (!Write)        state_d = LOAD;
          else if (Size == SZ_WORD) state_d = STORE;
          else                    state_d = RMW_RD;
        end
      end
      LOAD: begin
        load_d  = extract_load(MemReadData, req_q.size, req_q.addr[1:0], req_q.sext);
        state_d = RESP;
      end
      STORE: state_d = RESP;
      RMW_RD: begin
        rdword_d = MemReadData;
        state_d  = RMW_WR;
      end
      RMW_WR: state_d = RESP;
      RESP: begin
        // Fault only has meaning during the response cycle; clear it here.
        fault_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, aborting any access.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      req_q    <= '0;
      fault_q  <= 1'b0;
      rdword_q <= '0;
      load_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      fault_q  <= fault_d;
      rdword_q <= rdword_d;
      load_q   <= load_d;
    end
  end

  // Memory-facing and CPU-facing outputs decoded from the current state.
  always_comb begin
    mem_phase      = (state_q == LOAD) || (state_q == STORE) ||
                     (state_q == RMW_RD) || (state_q == RMW_WR);
    wr_phase       = (state_q == STORE) || (state_q == RMW_WR);
    Busy           = (state_q != IDLE);
    Done           = (state_q == RESP);
    Fault          = Done & fault_q;
    LoadData       = load_q;
    MemAddress     = mem_phase ? {req_q.addr[31:2], 2'b00} : 32'h0;
    MemWriteData   = 32'h0;
    if (state_q == STORE)
      MemWriteData = req_q.wdata;
    else if (state_q == RMW_WR)
      MemWriteData = merge_store(rdword_q, req_q.size, req_q.addr[1:0], req_q.wdata);
    // Reset gates the strobe immediately so an aborted access never writes.
    MemEnableWrite = wr_phase & req_q.write & ~Reset;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: combinational word memory, expected writes and
// responses queued at stimulus time and compared against what the DUT emits.
module tb_load_store_unit;

  logic        Clock = 1'b0;
  logic        Reset, Request, Write, SignExtend;
  logic [1:0]  Size;
  logic [31:0] Address, StoreData;
  logic        Busy, Done, Fault, MemEnableWrite;
  logic [31:0] LoadData, MemAddress, MemWriteData, MemReadData;

  logic [31:0] mem    [16];
  logic [31:0] shadow [16];

  typedef struct packed { logic [7:0] cyc; logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic [7:0] cyc; logic fault; logic [31:0] ld; } rsp_t;

  wr_t  exp_wr[$], obs_wr[$];
  rsp_t exp_rsp[$], obs_rsp[$];

  int          checks = 0;
  int          errors = 0;
  logic        busy1;
  logic [31:0] exp_ld;

  always #5 Clock = ~Clock;

  assign MemReadData = mem[MemAddress[5:2]];

  load_store_unit dut (
    .Clock(Clock), .Reset(Reset), .Request(Request), .Write(Write), .Size(Size),
    .SignExtend(SignExtend), .Address(Address), .StoreData(StoreData),
    .Busy(Busy), .Done(Done), .Fault(Fault), .LoadData(LoadData),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemEnableWrite(MemEnableWrite), .MemReadData(MemReadData)
  );

  function automatic logic mdl_fault(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] off, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = w[16*off[1] +: 16];
    if (sz == 2'b00) return sx ? {{24{b[7]}}, b} : {24'h0, b};
    if (sz == 2'b01) return sx ? {{16{h[15]}}, h} : {16'h0, h};
    return w;
  endfunction

  function automatic logic [31:0] mdl_store(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) r[8*off +: 8] = d[7:0];
    else             r[16*off[1] +: 16] = d[15:0];
    return r;
  endfunction

  // Issue one access in an IDLE cycle (cycle N) and record writes/responses
  // with their cycle offset from N; the bench memory absorbs each write.
  task automatic access(input logic wr, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d);
    bit seen;
    @(posedge Clock); #1;
    Request = 1'b1; Write = wr; Size = sz; SignExtend = sx; Address = a; StoreData = d;
    seen = 1'b0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(posedge Clock); #1;
      if (k == 1) Request = 1'b0;
      @(negedge Clock);
      if (k == 1) busy1 = Busy;
      if (MemEnableWrite) begin
        obs_wr.push_back({8'(k), MemAddress, MemWriteData});
        mem[MemAddress[5:2]] = MemWriteData;
      end
      if (Done) begin
        obs_rsp.push_back({8'(k), Fault, LoadData});
        seen = 1'b1;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL access_timeout: Done=0 for 8 cycles, required Done=1 (addr=%h)", a);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; Request = 1'b0; Write = 1'b0; Size = 2'b00; SignExtend = 1'b0;
    Address = '0; StoreData = '0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    checks++;
    if ({Busy, Done, Fault, MemEnableWrite} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 0000", {Busy, Done, Fault, MemEnableWrite});
    end
    checks++;
    if ({MemAddress, MemWriteData} !== 64'h0) begin
      errors++;
      $display("FAIL reset_mem_bus: got addr=%h wdata=%h, required 0", MemAddress, MemWriteData);
    end
    checks++;
    if (LoadData !== 32'h0) begin
      errors++;
      $display("FAIL reset_loaddata: got %h, required 0", LoadData);
    end
    @(posedge Clock); #1;
    Reset = 1'b0;
    exp_ld = 32'h0;
  endtask

  task automatic test_load_extend;
    rsp_t er, orr;
    mem[1] = 32'h80706050; shadow[1] = 32'h80706050;
    exp_rsp.push_back({8'd2, 1'b0, 32'hFFFFFF80});
    access(1'b0, 2'b00, 1'b1, 32'h7, 32'h0);
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL load_busy: got Busy=%b at N+1, required 1", busy1);
    end
    exp_rsp.push_back({8'd2, 1'b0, 32'h00000080});
    access(1'b0, 2'b00, 1'b0, 32'h7, 32'h0);
    exp_ld = 32'h00000080;
    while (exp_rsp.size() > 0) begin
      er = exp_rsp.pop_front(); orr = '1;
      if (obs_rsp.size() > 0) orr = obs_rsp.pop_front();
      checks++;
      if (orr !== er) begin
        errors++;
        $display("FAIL load_extend_rsp: got %h, required %h (cyc,fault,ld)", orr, er);
      end
    end
    checks++;
    if (obs_wr.size() != 0 || obs_rsp.size() != 0) begin
      errors++;
      $display("FAIL load_extend_extra: got %0d writes %0d rsps, required 0", obs_wr.size(), obs_rsp.size());
      obs_wr.delete(); obs_rsp.delete();
    end
  endtask

  task automatic test_halfword_store;
    wr_t ew, ow;
    rsp_t er, orr;
    mem[2] = 32'h11223344; shadow[2] = 32'hBEEF3344;
    exp_wr.push_back({8'd2, 32'h8, 32'hBEEF3344});
    exp_rsp.push_back({8'd3, 1'b0, exp_ld});
    access(1'b1, 2'b01, 1'b0, 32'hA, 32'h0000BEEF);
    while (exp_wr.size() > 0) begin
      ew = exp_wr.pop_front(); ow = '1;
      if (obs_wr.size() > 0) ow = obs_wr.pop_front();
      checks++;
      if (ow !== ew) begin
        errors++;
        $display("FAIL half_store_wr: got %h, required %h (cyc,addr,data)", ow, ew);
      end
    end
    while (exp_rsp.size() > 0) begin
      er = exp_rsp.pop_front(); orr = '1;
      if (obs_rsp.size() > 0) orr = obs_rsp.pop_front();
      checks++;
      if (orr !== er) begin
        errors++;
        $display("FAIL half_store_rsp: got %h, required %h (cyc,fault,ld)", orr, er);
      end
    end
    checks++;
    if (obs_wr.size() != 0 || obs_rsp.size() != 0) begin
      errors++;
      $display("FAIL half_store_extra: got %0d writes %0d rsps, required 0", obs_wr.size(), obs_rsp.size());
      obs_wr.delete(); obs_rsp.delete();
    end
  endtask

  task automatic test_word_store;
    wr_t ew, ow;
    rsp_t er, orr;
    shadow[4] = 32'hDEADBEEF;
    exp_wr.push_back({8'd1, 32'h10, 32'hDEADBEEF});
    exp_rsp.push_back({8'd2, 1'b0, exp_ld});
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    while (exp_wr.size() > 0) begin
      ew = exp_wr.pop_front(); ow = '1;
      if (obs_wr.size() > 0) ow = obs_wr.pop_front();
      checks++;
      if (ow !== ew) begin
        errors++;
        $display("FAIL word_store_wr: got %h, required %h (cyc,addr,data)", ow, ew);
      end
    end
    while (exp_rsp.size() > 0) begin
      er = exp_rsp.pop_front(); orr = '1;
      if (obs_rsp.size() > 0) orr = obs_rsp.pop_front();
      checks++;
      if (orr !== er) begin
        errors++;
        $display("FAIL word_store_rsp: got %h, required %h (cyc,fault,ld)", orr, er);
      end
    end
    checks++;
    if (obs_wr.size() != 0 || obs_rsp.size() != 0) begin
      errors++;
      $display("FAIL word_store_extra: got %0d writes %0d rsps, required 0", obs_wr.size(), obs_rsp.size());
      obs_wr.delete(); obs_rsp.delete();
    end
  endtask

  task automatic test_fault;
    rsp_t er, orr;
    mem[3] = 32'h12345678; shadow[3] = 32'h12345678;
    exp_rsp.push_back({8'd2, 1'b0, 32'h12345678});
    access(1'b0, 2'b10, 1'b0, 32'hC, 32'h0);
    exp_ld = 32'h12345678;
    exp_rsp.push_back({8'd1, 1'b1, 32'h12345678});
    access(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);            // misaligned word load
    exp_rsp.push_back({8'd1, 1'b1, 32'h12345678});
    access(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF);    // illegal size store
    exp_rsp.push_back({8'd1, 1'b1, 32'h12345678});
    access(1'b1, 2'b01, 1'b0, 32'h3, 32'h0000AAAA);     // odd halfword store
    exp_rsp.push_back({8'd1, 1'b1, 32'h12345678});
    access(1'b0, 2'b01, 1'b1, 32'h5, 32'h0);            // odd halfword load
    while (exp_rsp.size() > 0) begin
      er = exp_rsp.pop_front(); orr = '1;
      if (obs_rsp.size() > 0) orr = obs_rsp.pop_front();
      checks++;
      if (orr !== er) begin
        errors++;
        $display("FAIL fault_rsp: got %h, required %h (cyc,fault,ld)", orr, er);
      end
    end
    checks++;
    if (obs_wr.size() != 0 || obs_rsp.size() != 0) begin
      errors++;
      $display("FAIL fault_extra: got %0d writes %0d rsps, required 0", obs_wr.size(), obs_rsp.size());
      obs_wr.delete(); obs_rsp.delete();
    end
  endtask

  task automatic test_random_mix;
    wr_t ew, ow;
    rsp_t er, orr;
    logic wr, sx;
    logic [1:0] sz;
    logic [31:0] a, d, nw;
    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom_range(0, 1)); sx = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3)); a = 32'($urandom_range(0, 63)); d = $urandom;
      if (mdl_fault(sz, a)) begin
        exp_rsp.push_back({8'd1, 1'b1, exp_ld});
      end else if (!wr) begin
        exp_ld = mdl_load(shadow[a[5:2]], sz, a[1:0], sx);
        exp_rsp.push_back({8'd2, 1'b0, exp_ld});
      end else if (sz == 2'b10) begin
        shadow[a[5:2]] = d;
        exp_wr.push_back({8'd1, a[31:2], 2'b00, d});
        exp_rsp.push_back({8'd2, 1'b0, exp_ld});
      end else begin
        nw = mdl_store(shadow[a[5:2]], sz, a[1:0], d);
        shadow[a[5:2]] = nw;
        exp_wr.push_back({8'd2, a[31:2], 2'b00, nw});
        exp_rsp.push_back({8'd3, 1'b0, exp_ld});
      end
      access(wr, sz, sx, a, d);
      while (exp_wr.size() > 0) begin
        ew = exp_wr.pop_front(); ow = '1;
        if (obs_wr.size() > 0) ow = obs_wr.pop_front();
        checks++;
        if (ow !== ew) begin
          errors++;
          $display("FAIL mix_wr[%0d]: got %h, required %h (cyc,addr,data)", i, ow, ew);
        end
      end
      while (exp_rsp.size() > 0) begin
        er = exp_rsp.pop_front(); orr = '1;
        if (obs_rsp.size() > 0) orr = obs_rsp.pop_front();
        checks++;
        if (orr !== er) begin
          errors++;
          $display("FAIL mix_rsp[%0d]: got %h, required %h (cyc,fault,ld)", i, orr, er);
        end
      end
      checks++;
      if (obs_wr.size() != 0 || obs_rsp.size() != 0) begin
        errors++;
        $display("FAIL mix_extra[%0d]: got %0d writes %0d rsps, required 0", i, obs_wr.size(), obs_rsp.size());
        obs_wr.delete(); obs_rsp.delete();
      end
    end
  endtask

  task automatic test_reset_mid_rmw;
    int wr_seen;
    mem[0] = 32'hAABBCCDD; shadow[0] = 32'hAABBCCDD;
    @(posedge Clock); #1;
    Request = 1'b1; Write = 1'b1; Size = 2'b00; SignExtend = 1'b0;
    Address = 32'h1; StoreData = 32'h55;
    @(posedge Clock); #1;
    Request = 1'b0; Reset = 1'b1;                       // cycle N+1: RMW_RD
    @(negedge Clock);
    checks++;
    if ({Busy, MemEnableWrite} !== 2'b10) begin
      errors++;
      $display("FAIL rmw_reset_during: got Busy,WE=%b, required 10", {Busy, MemEnableWrite});
    end
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(negedge Clock);
    checks++;
    if ({Busy, Done, Fault, MemEnableWrite, MemAddress, MemWriteData, LoadData} !== 100'h0) begin
      errors++;
      $display("FAIL rmw_reset_after: got B%b D%b F%b WE%b A=%h WD=%h LD=%h, required all 0",
               Busy, Done, Fault, MemEnableWrite, MemAddress, MemWriteData, LoadData);
    end
    exp_ld = 32'h0;
    wr_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      if (MemEnableWrite) wr_seen++;
    end
    checks++;
    if (wr_seen != 0 || mem[0] !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL rmw_reset_nowrite: got %0d writes mem0=%h, required 0 and aabbccdd", wr_seen, mem[0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] done_mask;
    logic        busy3;
    logic [31:0] ld5;
    done_mask = '0; busy3 = 1'b1; ld5 = '0;
    @(posedge Clock); #1;
    Request = 1'b1; Write = 1'b0; Size = 2'b10; SignExtend = 1'b0; Address = 32'h4;
    for (int k = 1; k <= 10; k++) begin
      @(posedge Clock); #1;
      if (k == 4) Request = 1'b0;
      @(negedge Clock);
      done_mask[k] = Done;
      if (k == 3) busy3 = Busy;
      if (k == 5) ld5 = LoadData;
    end
    exp_ld = shadow[1];
    checks++;
    if (done_mask !== 11'b00000100100) begin
      errors++;
      $display("FAIL b2b_done: got Done cycles %b, required 00000100100", done_mask);
    end
    checks++;
    if (busy3 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap: got Busy=%b at N+3, required 0", busy3);
    end
    checks++;
    if (ld5 !== exp_ld) begin
      errors++;
      $display("FAIL b2b_loaddata: got %h, required %h", ld5, exp_ld);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
      shadow[i] = mem[i];
    end
    test_reset;
    test_load_extend;
    test_halfword_store;
    test_word_store;
    test_fault;
    test_random_mix;
    test_reset_mid_rmw;
    test_back_to_back;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[i] !== shadow[i]) begin
        errors++;
        $display("FAIL mem_final[%0d]: got %h, required %h", i, mem[i], shadow[i]);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
